// File: rtl/regfile_dump_port.sv
// Debug read-out engine on the register file's second read port.
// Sweeps an inclusive index range and streams each entry with its index over valid/ready.
module regfile_dump_port #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] first_addr,
   input  logic [ADDR_W-1:0] last_addr,
   input  logic              abort,
   output logic [ADDR_W-1:0] rf_read_address,
   input  logic [DATA_W-1:0] rf_read_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W-1:0] out_index,
   output logic              out_last,
   output logic              busy,
   output logic              done
);

   // state | meaning
   // IDLE  | waiting for start; start is ignored in every other state
   // FETCH | rf_read_address is stable, read data is captured at the next edge
   // HOLD  | word offered on the output until the host accepts it
   // DONE  | one-cycle completion pulse, then back to IDLE
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] end_addr;
   logic              range_ok;
   logic              handshake;

   assign range_ok  = (first_addr <= last_addr);
   assign handshake = (state == HOLD) && out_valid && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = range_ok ? FETCH : DONE;
            end
         end
         FETCH: state_nxt = HOLD;
         HOLD: begin
            if (handshake) begin
               state_nxt = out_last ? DONE : FETCH;
            end
         end
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      // abort beats the handshake and suppresses the done pulse
      if (abort && (state != IDLE)) begin
         state_nxt = IDLE;
      end
   end

   // rf_read_address doubles as the running index; termination on idx==end means it never wraps
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_read_address <= '0;
         end_addr        <= '0;
         out_valid       <= 1'b0;
         out_data        <= '0;
         out_index       <= '0;
         out_last        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start && range_ok) begin
                  rf_read_address <= first_addr;
                  end_addr        <= last_addr;
               end
            end
            FETCH: begin
               if (abort) begin
                  out_valid <= 1'b0;
               end else begin
                  out_data  <= rf_read_data;
                  out_index <= rf_read_address;
                  out_last  <= (rf_read_address == end_addr);
                  out_valid <= 1'b1;
               end
            end
            HOLD: begin
               if (abort) begin
                  out_valid <= 1'b0;
               end else if (handshake) begin
                  out_valid <= 1'b0;
                  if (!out_last) begin
                     rf_read_address <= rf_read_address + ADDR_W'(1);
                  end
               end
            end
            DONE: out_valid <= 1'b0;
            default: out_valid <= 1'b0;
         endcase
      end
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE) && !abort;

endmodule
